// File: rtl/data_sram_resp_if.sv
// Initiator-side SRAM request/response bus shared by data_sram_resp and its initiator.
interface data_sram_resp_if;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_rvalid;
  logic        sram_stall;

  modport master (
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata, sram_rvalid, sram_stall
  );

  modport slave (
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata, sram_rvalid, sram_stall
  );
endinterface

// File: rtl/data_sram_resp.sv
// Single-port 32-bit data SRAM with read-first byte-lane writes and a read-only debug port.
// Optional wait-state sequencer enabled by defining DATA_SRAM_RESP_WAIT_EN.
module data_sram_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  data_sram_resp_if.slave  bus,
  input  logic [31:0]      dbg_addr,
  output logic [31:0]      dbg_data
);

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [3:0]        wen
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc_en_p0;
  logic [3:0]        acc_wen_p0;
  logic [ADDR_W-1:0] acc_idx_p0;
  logic [DATA_W-1:0] acc_wdata_p0;
  logic              stall_p0;
  logic [ADDR_W-1:0] dbg_idx_p0;

  logic [DATA_W-1:0] rdata_p1;
  logic              vld_p1;
  logic [DATA_W-1:0] dbg_data_p1;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.sram_addr[31:ADDR_W+2], bus.sram_addr[1:0],
                              dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

  assign dbg_idx_p0 = dbg_addr[ADDR_W+1:2];

  // ---- stage 0: request acceptance / access selection ----
`ifdef DATA_SRAM_RESP_WAIT_EN
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WAIT  = 1'b1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  logic [0:0]        state_p0, state_nx;
  logic [3:0]        cnt_p0, cnt_nx;
  logic [3:0]        req_wen_p0, req_wen_nx;
  logic [ADDR_W-1:0] req_idx_p0, req_idx_nx;
  logic [DATA_W-1:0] req_wdata_p0, req_wdata_nx;

  always_comb begin
    state_nx     = state_p0;
    cnt_nx       = cnt_p0;
    req_wen_nx   = req_wen_p0;
    req_idx_nx   = req_idx_p0;
    req_wdata_nx = req_wdata_p0;
    acc_en_p0    = 1'b0;
    acc_wen_p0   = req_wen_p0;
    acc_idx_p0   = req_idx_p0;
    acc_wdata_p0 = req_wdata_p0;
    stall_p0     = 1'b0;
    case (state_p0)
      S_IDLE: begin
        if (bus.sram_en) begin
          if (WAIT_CYCLES == 0) begin
            acc_en_p0    = 1'b1;
            acc_wen_p0   = bus.sram_wen;
            acc_idx_p0   = bus.sram_addr[ADDR_W+1:2];
            acc_wdata_p0 = bus.sram_wdata;
          end else begin
            req_wen_nx   = bus.sram_wen;
            req_idx_nx   = bus.sram_addr[ADDR_W+1:2];
            req_wdata_nx = bus.sram_wdata;
            cnt_nx       = WAIT_LD;
            state_nx     = S_WAIT;
            stall_p0     = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_p0 != 4'd0) begin
          stall_p0 = 1'b1;
          cnt_nx   = cnt_p0 - 4'd1;
        end else begin
          acc_en_p0 = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= S_IDLE;
      cnt_p0   <= 4'd0;
    end else begin
      state_p0 <= state_nx;
      cnt_p0   <= cnt_nx;
    end
  end

  // Latched request payload is only consumed after a fresh acceptance, so it needs no reset.
  always_ff @(posedge clk) begin
    req_wen_p0   <= req_wen_nx;
    req_idx_p0   <= req_idx_nx;
    req_wdata_p0 <= req_wdata_nx;
  end
`else
  always_comb begin
    acc_en_p0    = bus.sram_en;
    acc_wen_p0   = bus.sram_wen;
    acc_idx_p0   = bus.sram_addr[ADDR_W+1:2];
    acc_wdata_p0 = bus.sram_wdata;
    stall_p0     = 1'b0;
  end
`endif

  // ---- stage 0 -> 1: storage write, registered read data ----
  always_ff @(posedge clk) begin
    if (!reset && acc_en_p0 && (acc_wen_p0 != 4'b0000)) begin
      mem[acc_idx_p0] <= lane_merge(mem[acc_idx_p0], acc_wdata_p0, acc_wen_p0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_p1    <= '0;
      vld_p1      <= 1'b0;
      dbg_data_p1 <= '0;
    end else begin
      vld_p1      <= acc_en_p0;
      if (acc_en_p0) rdata_p1 <= mem[acc_idx_p0];
      dbg_data_p1 <= mem[dbg_idx_p0];
    end
  end

  assign bus.sram_rdata  = rdata_p1;
  assign bus.sram_rvalid = vld_p1;
  assign bus.sram_stall  = stall_p0;
  assign dbg_data        = dbg_data_p1;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp; exercises wait-state mode when DATA_SRAM_RESP_WAIT_EN is defined.
module tb_data_sram_resp;
  localparam int ADDR_W      = 10;
  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_data;

  data_sram_resp_if bus ();

  data_sram_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.sram_en    = en;
    bus.sram_wen   = wen;
    bus.sram_addr  = addr;
    bus.sram_wdata = wdata;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata"},  bus.sram_rdata, 32'h0);
    check({tag, "_rvalid"}, {31'd0, bus.sram_rvalid}, 32'd0);
    check({tag, "_stall"},  {31'd0, bus.sram_stall}, 32'd0);
    check({tag, "_dbg"},    dbg_data, 32'h0);
  endtask

`ifdef DATA_SRAM_RESP_WAIT_EN
  // Present one request, hold it while stalled, then expect a single rvalid pulse.
  task automatic wait_access(input string tag, input logic [3:0] wen, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rd);
    int stalls;
    int early_vld;
    stalls    = 0;
    early_vld = 0;
    drive(1'b1, wen, addr, wdata);
    #1;
    for (int k = 0; k < 40 && bus.sram_stall; k++) begin
      stalls++;
      tick;
      if (bus.sram_rvalid) early_vld++;
    end
    check({tag, "_stall_cycles"}, stalls, WAIT_CYCLES);
    check({tag, "_early_rvalid"}, early_vld, 0);
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    tick;
    check({tag, "_rvalid"}, {31'd0, bus.sram_rvalid}, 32'd1);
    rd = bus.sram_rdata;
    tick;
    check({tag, "_rvalid_drop"}, {31'd0, bus.sram_rvalid}, 32'd0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    reset    = 1'b1;
    dbg_addr = 32'h0;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    tick;
    tick;
    check_reset_outputs("reset");
    reset = 1'b0;

`ifdef DATA_SRAM_RESP_WAIT_EN
    wait_access("w_wr10", 4'hF, 32'h10, 32'h1122_3344, rd);
    wait_access("w_rd10", 4'h0, 32'h10, 32'h0, rd);
    check("w_rd10_data", rd, 32'h1122_3344);
    wait_access("w_part", 4'b0101, 32'h10, 32'hAABB_CCDD, rd);
    check("w_part_readfirst", rd, 32'h1122_3344);
    wait_access("w_alias", 4'h0, 32'h1010, 32'h0, rd);
    check("w_alias_data", rd, 32'h11BB_33DD);

    // Write accepted, then reset lands while it is still waiting.
    drive(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    tick;
    reset = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    tick;
    check_reset_outputs("abort");
    reset = 1'b0;
    tick;
    check("abort_no_rvalid1", {31'd0, bus.sram_rvalid}, 32'd0);
    tick;
    check("abort_no_rvalid2", {31'd0, bus.sram_rvalid}, 32'd0);
    wait_access("w_after_abort", 4'h0, 32'h10, 32'h0, rd);
    check("w_after_abort_data", rd, 32'h11BB_33DD);
`else
    drive(1'b1, 4'hF, 32'h10, 32'h1122_3344);
    tick;
    check("wr10_rvalid", {31'd0, bus.sram_rvalid}, 32'd1);
    check("wr10_stall", {31'd0, bus.sram_stall}, 32'd0);

    drive(1'b1, 4'h0, 32'h10, 32'h0);
    dbg_addr = 32'h10;
    tick;
    check("rd10_rvalid", {31'd0, bus.sram_rvalid}, 32'd1);
    check("rd10_data", bus.sram_rdata, 32'h1122_3344);
    check("dbg10", dbg_data, 32'h1122_3344);

    drive(1'b1, 4'b0101, 32'h10, 32'hAABB_CCDD);
    tick;
    check("part_readfirst", bus.sram_rdata, 32'h1122_3344);
    check("dbg_same_cycle_old", dbg_data, 32'h1122_3344);

    drive(1'b1, 4'h0, 32'h10, 32'h0);
    tick;
    check("part_merged", bus.sram_rdata, 32'h11BB_33DD);
    check("dbg_after_part", dbg_data, 32'h11BB_33DD);

    drive(1'b0, 4'h0, 32'h10, 32'h0);
    tick;
    check("idle_rvalid", {31'd0, bus.sram_rvalid}, 32'd0);
    check("idle_rdata_hold", bus.sram_rdata, 32'h11BB_33DD);

    drive(1'b1, 4'h0, 32'h1013, 32'h0);
    tick;
    check("alias_data", bus.sram_rdata, 32'h11BB_33DD);

    drive(1'b1, 4'hF, 32'h0, 32'hA0A0_0001);
    tick;
    drive(1'b1, 4'hF, 32'h4, 32'hB0B0_0002);
    tick;
    drive(1'b1, 4'hF, 32'h8, 32'hC0C0_0003);
    tick;
    drive(1'b1, 4'h0, 32'h0, 32'h0);
    dbg_addr = 32'h4;
    tick;
    check("b2b0_rvalid", {31'd0, bus.sram_rvalid}, 32'd1);
    check("b2b0_data", bus.sram_rdata, 32'hA0A0_0001);
    check("dbg4", dbg_data, 32'hB0B0_0002);
    drive(1'b1, 4'h0, 32'h4, 32'h0);
    tick;
    check("b2b1_rvalid", {31'd0, bus.sram_rvalid}, 32'd1);
    check("b2b1_data", bus.sram_rdata, 32'hB0B0_0002);
    drive(1'b1, 4'h0, 32'h8, 32'h0);
    tick;
    check("b2b2_rvalid", {31'd0, bus.sram_rvalid}, 32'd1);
    check("b2b2_data", bus.sram_rdata, 32'hC0C0_0003);
    check("b2b2_stall", {31'd0, bus.sram_stall}, 32'd0);

    // Reset wins over a simultaneous write; storage keeps its contents.
    reset = 1'b1;
    drive(1'b1, 4'hF, 32'h0, 32'hDEAD_BEEF);
    tick;
    check_reset_outputs("rst_prio");
    reset = 1'b0;
    drive(1'b1, 4'h0, 32'h0, 32'h0);
    tick;
    check("rst_prio_kept", bus.sram_rdata, 32'hA0A0_0001);
    drive(1'b1, 4'h0, 32'h10, 32'h0);
    tick;
    check("rst_mem_kept", bus.sram_rdata, 32'h11BB_33DD);
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    tick;
    check("end_rvalid", {31'd0, bus.sram_rvalid}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; storage depth 2^ADDR_W 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states per access; used only when DATA_SRAM_RESP_WAIT_EN is defined; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sram_en  input  1  request valid from the initiator.
REQ-006 sram_wen  input  4  byte write enables; 4'b0000 with sram_en=1 is a read.
REQ-007 sram_addr  input  32  byte address; bits [ADDR_W+1:2] select the word.
REQ-008 sram_wdata  input  32  write data, lane i = bits [8i+7:8i].
REQ-009 sram_rdata  output  32  read data, registered.
REQ-010 sram_rvalid  output  1  one-cycle pulse marking sram_rdata valid.
REQ-011 sram_stall  output  1  initiator holds its request stable while high.
REQ-012 dbg_addr  input  32  display read-port byte address.
REQ-013 dbg_data  output  32  display read-port data, registered, one-cycle latency.

Function
REQ-014 Base mode: request sampled at edge t -> access performed at t; sram_rdata/sram_rvalid valid in cycle t+1; sram_stall tied 0.
REQ-015 Reads and writes SHALL return sram_rdata = word contents before that access (read-first), including partial-lane writes.
REQ-016 Writes SHALL update only lanes with sram_wen[i]=1; other lanes unchanged.
REQ-017 sram_en=0: no access, sram_rvalid=0, sram_rdata holds last value.
REQ-018 Address bits above ADDR_W+1 and bits [1:0] ignored (aliasing/wrap, no error).
REQ-019 dbg port SHALL never write; on same-cycle write to the dbg word, dbg_data returns old contents.
REQ-020 Back-to-back requests every cycle SHALL be accepted in base mode with no bubbles.

Reset
REQ-021 reset=1: sram_rdata=0, sram_rvalid=0, sram_stall=0, dbg_data=0, FSM=IDLE, wait counter=0.
REQ-022 Storage array SHALL NOT be cleared by reset.
REQ-023 Reset during a pending wait-mode access aborts it: no write committed, no sram_rvalid pulse.
REQ-024 Reset has priority over any simultaneous request.

Configuration
REQ-025 Macro DATA_SRAM_RESP_WAIT_EN: when undefined, base mode only (REQ-014); FSM and counter absent.
REQ-026 When defined: FSM states IDLE, WAIT; request accepted only in IDLE.
REQ-027 IDLE, sram_en=1, WAIT_CYCLES=0: access immediately, behaviour identical to base mode.
REQ-028 IDLE, sram_en=1, WAIT_CYCLES=N>0: latch wen/addr/wdata, counter=N-1, go WAIT; sram_stall=1 combinationally.
REQ-029 WAIT: sram_stall=(counter!=0); counter!=0 -> decrement; counter==0 -> perform latched access, go IDLE.
REQ-030 Wait-mode timing: request first presented cycle t -> stall high t..t+N-1, low t+N, sram_rvalid pulse t+N+1.
REQ-031 Bus inputs in WAIT ignored; a changed request during stall is a protocol violation, not checked.

Verification
REQ-032 Base: write addr 0x10 wdata 0x11223344 wen 4'hF, then read 0x10 -> rvalid next cycle, rdata 0x11223344.
REQ-033 Base: word 0x10=0x11223344, write wen 4'b0101 wdata 0xAABBCCDD -> rdata returned 0x11223344; later read -> 0x11BB33DD.
REQ-034 Base: read addr 0x1010 with ADDR_W=10 -> returns word at 0x10 (alias).
REQ-035 WAIT_EN, N=2: read presented cycle 5 -> stall 1 in cycles 5,6; 0 in 7; rvalid only in 8.
REQ-036 WAIT_EN, N=2: write presented cycle 5, reset asserted cycle 6 -> no rvalid; subsequent read shows old contents; outputs 0 after reset.
REQ-037 Back-to-back base-mode reads of 0x0,0x4,0x8 in consecutive cycles -> three consecutive rvalid pulses with matching data.
